// File: rtl/nbody_step_scheduler.sv
// nbody_step_scheduler
// Sequences one gravity-simulation timestep over the shared force and
// integration datapaths: clear accumulators, issue every body pair to the
// force datapath, drain, then issue every body index to the integration
// datapath, drain, and report DONE.
//
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   START                   level request, one timestep per assertion
//   NUM_BODIES              body count, latched (clamped) when leaving IDLE
//   clear_accs              one-cycle accumulator clear pulse
//   PAIR_VALID/READY/I/J    force-datapath job handshake
//   PAIR_RET                force job retired (pulse)
//   INTEG_VALID/READY/IDX   integration-datapath job handshake
//   INTEG_RET               integration job retired (pulse)
//   BUSY, DONE, ERR         status; ERR is sticky until RESET
//
// Build option: define GRAV_FULL_PAIRS_EN to issue all ordered pairs (i != j)
// instead of the unordered pairs i < j.

module nbody_step_scheduler #(
  parameter int MAX_BODIES      = 10,
  parameter int IDX_W           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [31:0]      NUM_BODIES,
  output logic             clear_accs,
  output logic             PAIR_VALID,
  input  logic             PAIR_READY,
  output logic [IDX_W-1:0] PAIR_I,
  output logic [IDX_W-1:0] PAIR_J,
  input  logic             PAIR_RET,
  output logic             INTEG_VALID,
  input  logic             INTEG_READY,
  output logic [IDX_W-1:0] INTEG_IDX,
  input  logic             INTEG_RET,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  // One extra bit so a body count equal to 2^IDX_W is representable.
  localparam int CNT_W = IDX_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_N   = CNT_W'(MAX_BODIES);
  localparam logic [OUT_W-1:0] OUT_LIM = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_CLEAR       = 3'd1,
    S_PAIR_ISSUE  = 3'd2,
    S_PAIR_DRAIN  = 3'd3,
    S_INTEG_ISSUE = 3'd4,
    S_INTEG_DRAIN = 3'd5,
    S_FINISH      = 3'd6
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] n_r, n_s;
  logic [IDX_W-1:0] pi_r, pj_r, pi_s, pj_s;
  logic [IDX_W-1:0] pi_nx_s, pj_nx_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [CNT_W-1:0] pi_ext_s, pj_ext_s, idx_ext_s;
  logic [OUT_W-1:0] out_r, out_s;
  logic             err_r, err_s;
  logic             pair_xfer_s, integ_xfer_s;
  logic             pair_ret_ok_s, integ_ret_ok_s, stray_s;
  logic             pair_last_s, integ_last_s, over_s;
`ifdef GRAV_FULL_PAIRS_EN
  logic [CNT_W-1:0] jc_s;
`endif

  assign pi_ext_s  = {1'b0, pi_r};
  assign pj_ext_s  = {1'b0, pj_r};
  assign idx_ext_s = {1'b0, idx_r};
  assign PAIR_I    = pi_r;
  assign PAIR_J    = pj_r;
  assign INTEG_IDX = idx_r;

  // Pair-order successor of the currently offered pair, and last-pair detect.
  always_comb begin
    pi_nx_s     = pi_r;
    pj_nx_s     = pj_r;
    pair_last_s = 1'b0;
`ifdef GRAV_FULL_PAIRS_EN
    pair_last_s = (pi_ext_s + CNT_W'(1) == n_r) && (pj_ext_s + CNT_W'(2) == n_r);
    // Step j, jumping over the diagonal j == i.
    jc_s = (pj_ext_s + CNT_W'(1) == pi_ext_s) ? pj_ext_s + CNT_W'(2)
                                              : pj_ext_s + CNT_W'(1);
    if (jc_s < n_r) begin
      pj_nx_s = jc_s[IDX_W-1:0];
    end else begin
      // New i is at least 1, so j = 0 is never on the diagonal.
      pi_nx_s = pi_r + IDX_W'(1);
      pj_nx_s = {IDX_W{1'b0}};
    end
`else
    pair_last_s = (pi_ext_s + CNT_W'(2) == n_r) && (pj_ext_s + CNT_W'(1) == n_r);
    if (pj_ext_s + CNT_W'(1) < n_r) begin
      pj_nx_s = pj_r + IDX_W'(1);
    end else begin
      pi_nx_s = pi_r + IDX_W'(1);
      pj_nx_s = pi_r + IDX_W'(2);
    end
`endif
  end

  // Handshake decode, retire qualification, outstanding count and error.
  always_comb begin
    pair_xfer_s    = PAIR_VALID & PAIR_READY;
    integ_xfer_s   = INTEG_VALID & INTEG_READY;
    integ_last_s   = (idx_ext_s + CNT_W'(1) == n_r);
    // A retire only counts in its own phase and against a live job.
    pair_ret_ok_s  = PAIR_RET & ((state_r == S_PAIR_ISSUE) | (state_r == S_PAIR_DRAIN))
                     & (out_r != {OUT_W{1'b0}});
    integ_ret_ok_s = INTEG_RET & ((state_r == S_INTEG_ISSUE) | (state_r == S_INTEG_DRAIN))
                     & (out_r != {OUT_W{1'b0}});
    stray_s        = (PAIR_RET & ~pair_ret_ok_s) | (INTEG_RET & ~integ_ret_ok_s);
    over_s         = (state_r == S_IDLE) & START & (NUM_BODIES > 32'(MAX_BODIES));
    err_s          = err_r | stray_s | over_s;
    case ({pair_xfer_s | integ_xfer_s, pair_ret_ok_s | integ_ret_ok_s})
      2'b10:   out_s = out_r + OUT_W'(1);
      2'b01:   out_s = out_r - OUT_W'(1);
      default: out_s = out_r;
    endcase
  end

  // Next-state and index sequencing.
  always_comb begin
    state_s = state_r;
    n_s     = n_r;
    pi_s    = pi_r;
    pj_s    = pj_r;
    idx_s   = idx_r;
    case (state_r)
      S_IDLE: begin
        if (START) begin
          state_s = S_CLEAR;
          n_s     = (NUM_BODIES > 32'(MAX_BODIES)) ? MAX_N : NUM_BODIES[CNT_W-1:0];
          pi_s    = {IDX_W{1'b0}};
          pj_s    = IDX_W'(1);
          idx_s   = {IDX_W{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (n_r == {CNT_W{1'b0}}) begin
          state_s = S_FINISH;
        end else if (n_r == CNT_W'(1)) begin
          state_s = S_INTEG_ISSUE;
        end else begin
          state_s = S_PAIR_ISSUE;
        end
      end
      S_PAIR_ISSUE: begin
        if (pair_xfer_s && pair_last_s) begin
          state_s = S_PAIR_DRAIN;
        end else if (pair_xfer_s) begin
          pi_s = pi_nx_s;
          pj_s = pj_nx_s;
        end else begin
          state_s = S_PAIR_ISSUE;
        end
      end
      S_PAIR_DRAIN: begin
        // Integration may only start once every force job has retired.
        if (out_s == {OUT_W{1'b0}}) begin
          state_s = S_INTEG_ISSUE;
        end else begin
          state_s = S_PAIR_DRAIN;
        end
      end
      S_INTEG_ISSUE: begin
        if (integ_xfer_s && integ_last_s) begin
          state_s = S_INTEG_DRAIN;
        end else if (integ_xfer_s) begin
          idx_s = idx_r + IDX_W'(1);
        end else begin
          state_s = S_INTEG_ISSUE;
        end
      end
      S_INTEG_DRAIN: begin
        if (out_s == {OUT_W{1'b0}}) begin
          state_s = S_FINISH;
        end else begin
          state_s = S_INTEG_DRAIN;
        end
      end
      S_FINISH: begin
        if (!START) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_FINISH;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State registers and registered outputs, derived from next-state values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= S_IDLE;
      n_r         <= {CNT_W{1'b0}};
      pi_r        <= {IDX_W{1'b0}};
      pj_r        <= {IDX_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      out_r       <= {OUT_W{1'b0}};
      err_r       <= 1'b0;
      clear_accs  <= 1'b0;
      PAIR_VALID  <= 1'b0;
      INTEG_VALID <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      state_r     <= state_s;
      n_r         <= n_s;
      pi_r        <= pi_s;
      pj_r        <= pj_s;
      idx_r       <= idx_s;
      out_r       <= out_s;
      err_r       <= err_s;
      clear_accs  <= (state_s == S_CLEAR);
      PAIR_VALID  <= (state_s == S_PAIR_ISSUE) && (out_s < OUT_LIM);
      INTEG_VALID <= (state_s == S_INTEG_ISSUE) && (out_s < OUT_LIM);
      BUSY        <= (state_s != S_IDLE) && (state_s != S_FINISH);
      DONE        <= (state_s == S_FINISH);
      ERR         <= err_s;
    end
  end

endmodule

// File: tb/tb_nbody_step_scheduler.sv
module tb_nbody_step_scheduler;

  localparam int MAXB    = 10;
  localparam int MAXO    = 4;
  localparam int RET_DLY = 3;
`ifdef GRAV_FULL_PAIRS_EN
  localparam int NP4 = 12, NP6 = 30, NP12 = 90;
`else
  localparam int NP4 = 6, NP6 = 15, NP12 = 45;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [31:0] NUM_BODIES = 32'd0;
  logic        PAIR_READY = 1'b1;
  logic        INTEG_READY = 1'b1;
  logic        PAIR_RET = 1'b0;
  logic        INTEG_RET = 1'b0;
  logic        clear_accs, PAIR_VALID, INTEG_VALID, BUSY, DONE, ERR;
  logic [3:0]  PAIR_I, PAIR_J, INTEG_IDX;

  nbody_step_scheduler dut (
    .CLK(CLK), .RESET(RESET), .START(START), .NUM_BODIES(NUM_BODIES),
    .clear_accs(clear_accs), .PAIR_VALID(PAIR_VALID), .PAIR_READY(PAIR_READY),
    .PAIR_I(PAIR_I), .PAIR_J(PAIR_J), .PAIR_RET(PAIR_RET),
    .INTEG_VALID(INTEG_VALID), .INTEG_READY(INTEG_READY), .INTEG_IDX(INTEG_IDX),
    .INTEG_RET(INTEG_RET), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (job lists + counters) ----------------
  // m_phase: 0 idle, 1 clear, 2 pair issue, 3 pair drain, 4 integ issue,
  //          5 integ drain, 6 finish
  int m_phase = 0, m_n = 0, m_out = 0, m_ppos = 0, m_ipos = 0;
  bit m_err = 1'b0;
  int m_pi[$], m_pj[$];

  always @(posedge CLK) begin : model_upd
    bit xp, xi, rp, ri;
    if (RESET) begin
      m_phase = 0; m_out = 0; m_err = 1'b0;
    end else begin
      xp = (m_phase == 2) && (m_out < MAXO) && PAIR_READY;
      xi = (m_phase == 4) && (m_out < MAXO) && INTEG_READY;
      rp = PAIR_RET && (m_phase == 2 || m_phase == 3) && (m_out > 0);
      ri = INTEG_RET && (m_phase == 4 || m_phase == 5) && (m_out > 0);
      if ((PAIR_RET && !rp) || (INTEG_RET && !ri)) m_err = 1'b1;
      m_out = m_out + ((xp || xi) ? 1 : 0) - ((rp || ri) ? 1 : 0);
      case (m_phase)
        0: if (START) begin
             m_n = (NUM_BODIES > 32'(MAXB)) ? MAXB : int'(NUM_BODIES);
             if (NUM_BODIES > 32'(MAXB)) m_err = 1'b1;
             m_pi.delete(); m_pj.delete();
`ifdef GRAV_FULL_PAIRS_EN
             for (int i = 0; i < m_n; i++)
               for (int j = 0; j < m_n; j++)
                 if (i != j) begin m_pi.push_back(i); m_pj.push_back(j); end
`else
             for (int i = 0; i < m_n - 1; i++)
               for (int j = i + 1; j < m_n; j++) begin m_pi.push_back(i); m_pj.push_back(j); end
`endif
             m_ppos = 0; m_ipos = 0; m_phase = 1;
           end
        1: m_phase = (m_n == 0) ? 6 : (m_n == 1) ? 4 : 2;
        2: if (xp) begin m_ppos++; if (m_ppos == m_pi.size()) m_phase = 3; end
        3: if (m_out == 0) m_phase = 4;
        4: if (xi) begin m_ipos++; if (m_ipos == m_n) m_phase = 5; end
        5: if (m_out == 0) m_phase = 6;
        6: if (!START) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // Compare process: every output against the model on every cycle.
  always @(negedge CLK) begin : compare
    bit pv, iv;
    if (run_chk) begin
      pv = (m_phase == 2) && (m_out < MAXO);
      iv = (m_phase == 4) && (m_out < MAXO);
      chk("clear_accs", clear_accs, m_phase == 1);
      chk("BUSY", BUSY, m_phase >= 1 && m_phase <= 5);
      chk("DONE", DONE, m_phase == 6);
      chk("ERR", ERR, m_err);
      chk("PAIR_VALID", PAIR_VALID, pv);
      chk("INTEG_VALID", INTEG_VALID, iv);
      if (pv) begin
        chk("PAIR_I", PAIR_I, m_pi[m_ppos]);
        chk("PAIR_J", PAIR_J, m_pj[m_ppos]);
      end
      if (iv) chk("INTEG_IDX", INTEG_IDX, m_ipos);
    end
  end

  // ---------------- retire responder and transfer capture ----------------
  int cyc = 0;
  int pq_p[$], pq_i[$];
  int cap_p[$], cap_i[$];
  bit auto_ret = 1'b1;
  int man_p = 0;

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (RESET) begin
      pq_p.delete(); pq_i.delete();
    end else begin
      if (PAIR_VALID && PAIR_READY) begin
        pq_p.push_back(cyc + RET_DLY);
        cap_p.push_back(int'(PAIR_I) * 16 + int'(PAIR_J));
      end
      if (INTEG_VALID && INTEG_READY) begin
        pq_i.push_back(cyc + RET_DLY);
        cap_i.push_back(int'(INTEG_IDX));
      end
    end
  end

  always @(negedge CLK) begin
    PAIR_RET = 1'b0;
    INTEG_RET = 1'b0;
    if (!RESET) begin
      if (man_p > 0) begin
        PAIR_RET = 1'b1; man_p--;
        if (pq_p.size() > 0) void'(pq_p.pop_front());
      end else if (auto_ret && pq_p.size() > 0 && pq_p[0] <= cyc) begin
        PAIR_RET = 1'b1; void'(pq_p.pop_front());
      end
      if (auto_ret && pq_i.size() > 0 && pq_i[0] <= cyc) begin
        INTEG_RET = 1'b1; void'(pq_i.pop_front());
      end
    end
  end

  function automatic int pget(int k);
    return (k < cap_p.size()) ? cap_p[k] : -1;
  endfunction
  function automatic int iget(int k);
    return (k < cap_i.size()) ? cap_i[k] : -1;
  endfunction

  task automatic tick(int k);
    repeat (k) @(negedge CLK);
  endtask

  task automatic start_step(int n);
    cap_p.delete(); cap_i.delete();
    NUM_BODIES = 32'(n);
    START = 1'b1;
  endtask

  task automatic wait_done_drop(input string nm);
    for (int k = 0; k < 3000 && DONE !== 1'b1; k++) @(negedge CLK);
    chk({nm, "_done_reached"}, DONE, 1);
    START = 1'b0;
    @(negedge CLK);
    chk({nm, "_done_fall"}, DONE, 0);
    chk({nm, "_busy_idle"}, BUSY, 0);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_clear"}, clear_accs, 0); chk({nm, "_pv"}, PAIR_VALID, 0);
    chk({nm, "_pi"}, PAIR_I, 0);        chk({nm, "_pj"}, PAIR_J, 0);
    chk({nm, "_iv"}, INTEG_VALID, 0);   chk({nm, "_idx"}, INTEG_IDX, 0);
    chk({nm, "_busy"}, BUSY, 0);        chk({nm, "_done"}, DONE, 0);
    chk({nm, "_err"}, ERR, 0);
  endtask

  int exp4[6] = '{1, 2, 3, 18, 19, 35};
  int exp4f[4] = '{1, 2, 3, 16};

  initial begin
    tick(3);
    run_chk = 1'b1;
    check_all_zero("reset");
    RESET = 1'b0;
    tick(1);

    // N=2: latency, single pair, two integration jobs
    start_step(2);
    tick(1);
    chk("t1_clear_lat", clear_accs, 1);
    chk("t1_pv_early", PAIR_VALID, 0);
    tick(1);
    chk("t1_pv_lat", PAIR_VALID, 1);
    chk("t1_pi0", PAIR_I, 0);
    chk("t1_pj1", PAIR_J, 1);
    wait_done_drop("t1");
    chk("t1_npairs", cap_p.size(), 1);
    chk("t1_pair01", pget(0), 1);
    chk("t1_ninteg", cap_i.size(), 2);
    chk("t1_idx0", iget(0), 0);
    chk("t1_idx1", iget(1), 1);

    // N=4: exact pair order
    start_step(4);
    wait_done_drop("t2");
    chk("t2_npairs", cap_p.size(), NP4);
`ifdef GRAV_FULL_PAIRS_EN
    for (int k = 0; k < 4; k++) chk("t2_pair_seq", pget(k), exp4f[k]);
`else
    for (int k = 0; k < 6; k++) chk("t2_pair_seq", pget(k), exp4[k]);
`endif
    chk("t2_ninteg", cap_i.size(), 4);

    // Backpressure mid-phase on N=4
    start_step(4);
    for (int k = 0; k < 50 && cap_p.size() < 2; k++) @(negedge CLK);
    PAIR_READY = 1'b0;
    chk("t3_bp_pv", PAIR_VALID, 1);
    chk("t3_bp_pi", PAIR_I, 0);
    chk("t3_bp_pj", PAIR_J, 3);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("t3_hold_pv", PAIR_VALID, 1);
      chk("t3_hold_pi", PAIR_I, 0);
      chk("t3_hold_pj", PAIR_J, 3);
    end
    PAIR_READY = 1'b1;
    wait_done_drop("t3");
    chk("t3_npairs", cap_p.size(), NP4);
`ifdef GRAV_FULL_PAIRS_EN
    for (int k = 0; k < 4; k++) chk("t3_pair_seq", pget(k), exp4f[k]);
`else
    for (int k = 0; k < 6; k++) chk("t3_pair_seq", pget(k), exp4[k]);
`endif

    // Outstanding limit with retires withheld, N=6
    auto_ret = 1'b0;
    start_step(6);
    tick(10);
    chk("t4_limit_n", cap_p.size(), 4);
    chk("t4_limit_pv", PAIR_VALID, 0);
    man_p = 1;
    tick(4);
    chk("t4_one_more", cap_p.size(), 5);
    chk("t4_full_again", PAIR_VALID, 0);
    man_p = 2;   // second retire coincides with a transfer
    tick(6);
    chk("t4_same_cycle", cap_p.size(), 7);
    chk("t4_full_pv", PAIR_VALID, 0);
    auto_ret = 1'b1;
    wait_done_drop("t4");
    chk("t4_npairs", cap_p.size(), NP6);
    chk("t4_ninteg", cap_i.size(), 6);

    // N=0: DONE two cycles after START, no jobs
    start_step(0);
    tick(1);
    chk("t5_clear", clear_accs, 1);
    tick(1);
    chk("t5_done", DONE, 1);
    wait_done_drop("t5");
    chk("t5_npairs", cap_p.size(), 0);
    chk("t5_ninteg", cap_i.size(), 0);

    // N=1: one integration job only
    start_step(1);
    wait_done_drop("t6");
    chk("t6_npairs", cap_p.size(), 0);
    chk("t6_ninteg", cap_i.size(), 1);
    chk("t6_idx0", iget(0), 0);

    // N=12: clamp to 10 and flag
    start_step(12);
    tick(1);
    chk("t7_err", ERR, 1);
    wait_done_drop("t7");
    chk("t7_npairs", cap_p.size(), NP12);
    chk("t7_ninteg", cap_i.size(), 10);
    chk("t7_last_idx", iget(9), 9);

    // Reset during PAIR_ISSUE, then a clean N=2 step
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    tick(1);
    start_step(6);
    for (int k = 0; k < 50 && cap_p.size() < 3; k++) @(negedge CLK);
    chk("t8_midphase", PAIR_VALID, 1);
    RESET = 1'b1;
    START = 1'b0;
    tick(1);
    check_all_zero("t8_abort");
    RESET = 1'b0;
    tick(2);
    start_step(2);
    wait_done_drop("t8");
    chk("t8_npairs", cap_p.size(), 1);
    chk("t8_pair01", pget(0), 1);
    chk("t8_ninteg", cap_i.size(), 2);
    chk("t8_err_clear", ERR, 0);

    // Stray PAIR_RET in IDLE
    man_p = 1;
    tick(3);
    chk("t9_stray_err", ERR, 1);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
